multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FSM sequencing fetch/decode/execute phases,
// with a bounded memory handshake, sticky fault reporting and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EX     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ANDI_EX  = 4'd12,
        S_IMM_WB   = 4'd13,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;

    // mem_ready on the timeout cycle takes priority, so it is tested first in each memory state.
    assign timed_out = (wait_q == TIMEOUT) && !mem_ready;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ANDI:      state_d = S_ANDI_EX;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)      state_d = S_MEM_WB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)      state_d = S_FETCH;
                else if (timed_out) state_d = S_FAULT;
            end
            S_R_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_ADDI_EX, S_ANDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (state_q == S_ANDI_EX) ? 2'b11 : 2'b00;
                state_d = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_d  = wait_q;
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        // Any state change clears the counter, which covers entry to every memory state.
        if (state_d != state_q)
            wait_d = '0;
        else if ((state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready)
            wait_d = wait_q + 8'd1;
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            fault_d = 1'b1;
            code_d  = (state_q == S_DECODE) ? 2'b01 : 2'b10;
        end
        if (state_d == S_FETCH &&
            (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected phase sequence
// (with inserted memory waits) and every cycle is compared against that plan.
module tb_multicycle_control;

    localparam int TO = 3;
    localparam int CW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    OpCode = '0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]    ALUOp, ALUSrcB, PCSource;
    logic [3:0]    state;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] instr_count;
    logic [15:0]   ctrl;

    int n_checks = 0;
    int n_errors = 0;
    int model_count = 0;
    logic [1:0] exp_code = 2'b00;
    logic [5:0] legal_ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI};

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .state(state), .fault(fault), .fault_code(fault_code),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Expected strobes per state, straight from the control table.
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, srca = 0, rw = 0, rdst = 0;
        logic [1:0] aop = 0, srcb = 0, pcs = 0;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            2:  srcb = 2'b11;
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin srca = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin srca = 1; srcb = 2'b10; end
            12: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
            13: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst, aop, srcb, pcs};
    endfunction

    task automatic step(input int st, input bit mr, input logic [5:0] op);
        mem_ready = mr;
        OpCode = op;
        #1;
        check("state", 32'(state), 32'(st));
        check("ctrl", 32'(ctrl), 32'(exp_ctrl(st, mr)));
        check("count", 32'(instr_count), 32'(model_count));
        check("fault", 32'({fault, fault_code}), (st == 15) ? 32'({1'b1, exp_code}) : 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = rb();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_fault", 32'({fault, fault_code}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        exp_code = 2'b00;
        #1;
        check("idle_state", 32'(state), 32'd0);
        check("idle_ctrl", 32'(ctrl), 32'd0);
        @(negedge clk);
    endtask

    task automatic fault_out(input logic [1:0] code);
        exp_code = code;
        repeat (20) step(15, rb(), 6'($urandom));
        do_reset();
    endtask

    task automatic mem_phase(input int st, input int waits, input logic [5:0] op,
                             output bit to);
        for (int i = 0; i < waits; i++) step(st, 1'b0, op);
        to = (waits > TO);
        if (!to) step(st, 1'b1, op);
    endtask

    // Runs one instruction from its first FETCH cycle; waits of TO+1 provoke a timeout.
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        bit to;
        mem_phase(1, fw, 6'($urandom), to);
        if (to) begin fault_out(2'b10); return; end
        step(2, rb(), op);
        case (op)
            OP_LW: begin
                step(3, rb(), op);
                mem_phase(4, mw, op, to);
                if (to) begin fault_out(2'b10); return; end
                step(5, rb(), op);
            end
            OP_SW: begin
                step(3, rb(), op);
                mem_phase(6, mw, op, to);
                if (to) begin fault_out(2'b10); return; end
            end
            OP_R:    begin step(7, rb(), op); step(8, rb(), op); end
            OP_BEQ:  step(9, rb(), op);
            OP_J:    step(10, rb(), op);
            OP_ADDI: begin step(11, rb(), op); step(13, rb(), op); end
            OP_ANDI: begin step(12, rb(), op); step(13, rb(), op); end
            default: begin fault_out(2'b01); return; end
        endcase
        model_count = (model_count + 1) % (1 << CW);
    endtask

    function automatic logic [5:0] illegal_op();
        logic [5:0] op;
        do op = 6'($urandom);
        while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI});
        return op;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        do_instr(OP_LW, 0, 0);
        check("lw_retired", 32'(instr_count), 32'd1);
        do_instr(OP_SW, 0, 3);
        check("sw_retired", 32'(instr_count), 32'd2);
        do_instr(OP_ANDI, 0, 0);
        do_instr(OP_R, TO, 0);
        do_instr(6'b111111, 0, 0);
        do_instr(OP_R, TO + 1, 0);
        do_instr(OP_LW, 0, TO + 1);
        do_instr(OP_SW, 1, TO + 1);

        repeat (17) do_instr(OP_J, 0, 0);
        check("cnt_wrap", 32'(instr_count), 32'd1);

        for (int n = 0; n < 150; n++) begin
            int sel = $urandom_range(0, 29);
            int fw  = (sel == 0) ? TO + 1 : $urandom_range(0, TO);
            int mw  = (sel == 1) ? TO + 1 : $urandom_range(0, TO);
            if (sel == 2) do_instr(illegal_op(), fw, mw);
            else          do_instr(legal_ops[$urandom_range(0, 6)], fw, mw);
        end

        do_reset();
        do_instr(OP_J, 0, 0);
        do_instr(OP_BEQ, 0, 0);
        step(1, 1'b1, 6'($urandom));
        step(2, rb(), OP_LW);
        step(3, rb(), OP_LW);
        step(4, 1'b0, OP_LW);
        mem_ready = 1'b0;
        #1;
        check("memrd_pending", 32'({MemRead, IorD}), 32'b11);
        #1;
        reset = 1'b1;
        #1;
        check("async_strobes", 32'({MemRead, IorD}), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        do_reset();
        do_instr(OP_ADDI, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
